// File: rtl/hpdcache_cmo_req_adapter.sv
// Front end of the HPDcache CMO handler: buffers core CMO requests, issues them to
// the handler one at a time as one-hot operations and returns optional completions.
module hpdcache_cmo_req_adapter #(
   parameter int unsigned FIFO_DEPTH  = 2,
   parameter int unsigned ADDR_WIDTH  = 49,
   parameter int unsigned WDATA_WIDTH = 64,
   parameter int unsigned SID_WIDTH   = 3,
   parameter int unsigned TID_WIDTH   = 6
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,

   input  logic                   core_req_valid_i,
   output logic                   core_req_ready_o,
   input  logic [2:0]             core_req_op_i,
   input  logic [ADDR_WIDTH-1:0]  core_req_addr_i,
   input  logic [WDATA_WIDTH-1:0] core_req_wdata_i,
   input  logic [SID_WIDTH-1:0]   core_req_sid_i,
   input  logic [TID_WIDTH-1:0]   core_req_tid_i,
   input  logic                   core_req_need_rsp_i,

   output logic                   cmo_req_valid_o,
   input  logic                   cmo_req_ready_i,
   output logic [3:0]             cmo_req_op_o,
   output logic [ADDR_WIDTH-1:0]  cmo_req_addr_o,
   output logic [WDATA_WIDTH-1:0] cmo_req_wdata_o,

   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [SID_WIDTH-1:0]   rsp_sid_o,
   output logic [TID_WIDTH-1:0]   rsp_tid_o,
   output logic                   rsp_error_o,

   output logic                   busy_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   typedef logic [PTR_W:0] ptr_t;

   typedef struct packed {
      logic [2:0]             op;
      logic [ADDR_WIDTH-1:0]  addr;
      logic [WDATA_WIDTH-1:0] wdata;
      logic [SID_WIDTH-1:0]   sid;
      logic [TID_WIDTH-1:0]   tid;
      logic                   need_rsp;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_DONE,
      RSP
   } state_e;

   entry_t               fifo_mem_q [FIFO_DEPTH];
   entry_t               entry_in;
   entry_t               head;
   ptr_t                 wr_ptr_q, wr_ptr_d;
   ptr_t                 rd_ptr_q, rd_ptr_d;
   logic                 fifo_full, fifo_empty;
   logic                 push, pop;
   logic                 head_legal;

   state_e               state_q, state_d;
   logic [SID_WIDTH-1:0] rsp_sid_q, rsp_sid_d;
   logic [TID_WIDTH-1:0] rsp_tid_q, rsp_tid_d;
   logic                 need_rsp_q, need_rsp_d;
   logic                 rsp_error_q, rsp_error_d;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign push       = core_req_valid_i & ~fifo_full;

   assign entry_in = '{op:       core_req_op_i,
                       addr:     core_req_addr_i,
                       wdata:    core_req_wdata_i,
                       sid:      core_req_sid_i,
                       tid:      core_req_tid_i,
                       need_rsp: core_req_need_rsp_i};

   assign head       = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
   assign head_legal = ~head.op[2];

   // NOTE: the storage array carries no reset; the pointers alone define which
   // entries are meaningful, so clearing the payload would only cost area.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= entry_in;
      end
   end

   // NOTE: every signal assigned in this block gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      rsp_sid_d   = rsp_sid_q;
      rsp_tid_d   = rsp_tid_q;
      need_rsp_d  = need_rsp_q;
      rsp_error_d = rsp_error_q;
      pop         = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               if (head_legal) begin
                  if (cmo_req_ready_i) begin
                     pop         = 1'b1;
                     state_d     = WAIT_DONE;
                     rsp_sid_d   = head.sid;
                     rsp_tid_d   = head.tid;
                     need_rsp_d  = head.need_rsp;
                     rsp_error_d = 1'b0;
                  end
               end else begin
                  // Illegal opcodes never reach the handler.
                  pop = 1'b1;
                  if (head.need_rsp) begin
                     state_d     = RSP;
                     rsp_sid_d   = head.sid;
                     rsp_tid_d   = head.tid;
                     need_rsp_d  = head.need_rsp;
                     rsp_error_d = 1'b1;
                  end
               end
            end
         end
         WAIT_DONE: begin
            if (cmo_req_ready_i) begin
               state_d = need_rsp_q ? RSP : IDLE;
            end
         end
         RSP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         state_q     <= IDLE;
         rsp_sid_q   <= '0;
         rsp_tid_q   <= '0;
         need_rsp_q  <= 1'b0;
         rsp_error_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         state_q     <= state_d;
         rsp_sid_q   <= rsp_sid_d;
         rsp_tid_q   <= rsp_tid_d;
         need_rsp_q  <= need_rsp_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   always_comb begin
      cmo_req_op_o = 4'b0000;
      case (head.op)
         3'd0:    cmo_req_op_o = 4'b0001;
         3'd1:    cmo_req_op_o = 4'b0010;
         3'd2:    cmo_req_op_o = 4'b0100;
         3'd3:    cmo_req_op_o = 4'b1000;
         default: cmo_req_op_o = 4'b0000;
      endcase
   end

   assign cmo_req_valid_o  = (state_q == IDLE) && !fifo_empty && head_legal;
   assign cmo_req_addr_o   = head.addr;
   assign cmo_req_wdata_o  = head.wdata;

   assign core_req_ready_o = ~fifo_full;
   assign rsp_valid_o      = (state_q == RSP);
   assign rsp_sid_o        = rsp_sid_q;
   assign rsp_tid_o        = rsp_tid_q;
   assign rsp_error_o      = rsp_error_q;
   assign busy_o           = ~fifo_empty | (state_q != IDLE);

endmodule

// File: tb/tb_hpdcache_cmo_req_adapter.sv
// Bench for hpdcache_cmo_req_adapter: vector table plus corner-case sequences, with
// issue/response scoreboards and a simple CMO handler model driving cmo_req_ready_i.
module tb_hpdcache_cmo_req_adapter;

   typedef struct {
      logic [2:0]  op;
      logic [48:0] addr;
      logic [63:0] wdata;
      logic [2:0]  sid;
      logic [5:0]  tid;
      logic        need_rsp;
      logic [3:0]  exp_op;
      logic        exp_issue;
      logic        exp_rsp;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [3:0]  op;
      logic [48:0] addr;
      logic [63:0] wdata;
   } iss_t;

   typedef struct {
      logic [2:0] sid;
      logic [5:0] tid;
      logic       err;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        core_req_valid_i;
   logic        core_req_ready_o;
   logic [2:0]  core_req_op_i;
   logic [48:0] core_req_addr_i;
   logic [63:0] core_req_wdata_i;
   logic [2:0]  core_req_sid_i;
   logic [5:0]  core_req_tid_i;
   logic        core_req_need_rsp_i;
   logic        cmo_req_valid_o;
   logic        cmo_req_ready_i;
   logic [3:0]  cmo_req_op_o;
   logic [48:0] cmo_req_addr_o;
   logic [63:0] cmo_req_wdata_o;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [2:0]  rsp_sid_o;
   logic [5:0]  rsp_tid_o;
   logic        rsp_error_o;
   logic        busy_o;

   hpdcache_cmo_req_adapter dut (
      .clk_i               (clk),
      .rst_ni              (rst_ni),
      .core_req_valid_i    (core_req_valid_i),
      .core_req_ready_o    (core_req_ready_o),
      .core_req_op_i       (core_req_op_i),
      .core_req_addr_i     (core_req_addr_i),
      .core_req_wdata_i    (core_req_wdata_i),
      .core_req_sid_i      (core_req_sid_i),
      .core_req_tid_i      (core_req_tid_i),
      .core_req_need_rsp_i (core_req_need_rsp_i),
      .cmo_req_valid_o     (cmo_req_valid_o),
      .cmo_req_ready_i     (cmo_req_ready_i),
      .cmo_req_op_o        (cmo_req_op_o),
      .cmo_req_addr_o      (cmo_req_addr_o),
      .cmo_req_wdata_o     (cmo_req_wdata_o),
      .rsp_valid_o         (rsp_valid_o),
      .rsp_ready_i         (rsp_ready_i),
      .rsp_sid_o           (rsp_sid_o),
      .rsp_tid_o           (rsp_tid_o),
      .rsp_error_o         (rsp_error_o),
      .busy_o              (busy_o)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   iss_t issue_q[$];
   rsp_t rsp_q[$];
   int   issue_hist[$];
   int   n_issue = 0;
   int   n_rsp = 0;
   int   n_valid_neg = 0;
   int   last_issue_edge = -1;
   int   last_rsp_edge = -1;
   int   rsp_vis_cyc = -1;
   int   ready_rise_cyc = -1;
   logic issue_fire = 1'b0;
   logic hdl_stall = 1'b0;
   int   hdl_lat = 0;
   int   hdl_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic [48:0] addr,
                               input logic [63:0] wdata, input logic [2:0] sid,
                               input logic [5:0] tid, input logic need,
                               input logic [3:0] eop, input logic eiss,
                               input logic ersp, input logic eerr);
      vec_t v;
      v.op = op; v.addr = addr; v.wdata = wdata; v.sid = sid; v.tid = tid;
      v.need_rsp = need; v.exp_op = eop; v.exp_issue = eiss; v.exp_rsp = ersp;
      v.exp_err = eerr;
      return v;
   endfunction

   // Handler model: idle means ready; after accepting it stays busy for hdl_lat cycles.
   initial forever begin
      @(posedge clk);
      #2;
      if (!rst_ni) begin
         hdl_cnt = 0;
         cmo_req_ready_i = !hdl_stall;
      end else if (issue_fire && hdl_lat > 0) begin
         hdl_cnt = hdl_lat;
         cmo_req_ready_i = 1'b0;
      end else if (hdl_cnt > 0) begin
         hdl_cnt--;
         if (hdl_cnt == 0) begin
            cmo_req_ready_i = !hdl_stall;
            ready_rise_cyc = cyc;
         end
      end else begin
         cmo_req_ready_i = !hdl_stall;
      end
      issue_fire = 1'b0;
   end

   // Monitor: samples handshakes mid-cycle and scores them against the queues.
   always @(negedge clk) begin
      iss_t ei;
      rsp_t er;
      if (cmo_req_valid_o) n_valid_neg++;
      if (cmo_req_valid_o && cmo_req_ready_i) begin
         n_issue++;
         last_issue_edge = cyc + 1;
         issue_hist.push_back(cyc + 1);
         issue_fire = 1'b1;
         if (issue_q.size() == 0) fail_now("unexpected_issue");
         else begin
            ei = issue_q.pop_front();
            check("issue_op", cmo_req_op_o, ei.op);
            check("issue_addr", cmo_req_addr_o, ei.addr);
            check("issue_wdata", cmo_req_wdata_o, ei.wdata);
         end
      end
      if (rsp_valid_o && rsp_vis_cyc < 0) rsp_vis_cyc = cyc;
      if (rsp_valid_o && rsp_ready_i) begin
         n_rsp++;
         last_rsp_edge = cyc + 1;
         if (rsp_q.size() == 0) fail_now("unexpected_rsp");
         else begin
            er = rsp_q.pop_front();
            check("rsp_sid", rsp_sid_o, er.sid);
            check("rsp_tid", rsp_tid_o, er.tid);
            check("rsp_error", rsp_error_o, er.err);
         end
      end
   end

   // Drives one request; returns the index of the clock edge that accepted it.
   task automatic push_req(input vec_t v, output int acc_edge);
      int n;
      iss_t ei;
      rsp_t er;
      n = 0;
      core_req_valid_i    = 1'b1;
      core_req_op_i       = v.op;
      core_req_addr_i     = v.addr;
      core_req_wdata_i    = v.wdata;
      core_req_sid_i      = v.sid;
      core_req_tid_i      = v.tid;
      core_req_need_rsp_i = v.need_rsp;
      @(negedge clk);
      while (!core_req_ready_o && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!core_req_ready_o) begin
         fail_now("push_accept_timeout");
         acc_edge = -1;
      end else begin
         acc_edge = cyc + 1;
         if (v.exp_issue) begin
            ei.op = v.exp_op; ei.addr = v.addr; ei.wdata = v.wdata;
            issue_q.push_back(ei);
         end
         if (v.exp_rsp) begin
            er.sid = v.sid; er.tid = v.tid; er.err = v.exp_err;
            rsp_q.push_back(er);
         end
      end
      @(posedge clk);
      #1;
      core_req_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (busy_o && n < budget) begin
         n++;
         @(negedge clk);
      end
      if (busy_o) fail_now(name);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[8];
      vec_t r;
      int   pe, ea, eb, ec, e1, n, n_iss0, n_rsp0, n_val0;

      vecs[0] = mk(3'd0, 49'h0_0000_1000, 64'h0,    3'd2, 6'h15, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0);
      vecs[1] = mk(3'd1, 49'h0_0001_2340, 64'h0,    3'd1, 6'h03, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
      vecs[2] = mk(3'd2, 49'h0_0000_0040, 64'h0F,   3'd3, 6'h2a, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
      vecs[3] = mk(3'd3, 49'h1_ABCD_0000, 64'h0,    3'd7, 6'h3f, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b0);
      vecs[4] = mk(3'd5, 49'h0_0000_0080, 64'h0,    3'd4, 6'h11, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
      vecs[5] = mk(3'd5, 49'h0_0000_00c0, 64'h0,    3'd4, 6'h12, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      vecs[6] = mk(3'd7, 49'h0_0000_0100, 64'h0,    3'd5, 6'h22, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
      vecs[7] = mk(3'd0, 49'h0_0000_0000, 64'h0,    3'd0, 6'h00, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);

      rst_ni = 1'b0;
      core_req_valid_i = 1'b0;
      core_req_op_i = '0;
      core_req_addr_i = '0;
      core_req_wdata_i = '0;
      core_req_sid_i = '0;
      core_req_tid_i = '0;
      core_req_need_rsp_i = 1'b0;
      rsp_ready_i = 1'b1;
      cmo_req_ready_i = 1'b1;

      @(negedge clk);
      check("reset_cmo_valid", cmo_req_valid_o, 0);
      check("reset_rsp_valid", rsp_valid_o, 0);
      check("reset_rsp_error", rsp_error_o, 0);
      check("reset_rsp_sid", rsp_sid_o, 0);
      check("reset_rsp_tid", rsp_tid_o, 0);
      check("reset_busy", busy_o, 0);
      check("reset_core_ready", core_req_ready_o, 1);
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      @(posedge clk);
      #1;

      // Vector table: handler always ready, responses accepted at once.
      for (int i = 0; i < 8; i++) begin
         n_iss0 = n_issue;
         n_rsp0 = n_rsp;
         n_val0 = n_valid_neg;
         push_req(vecs[i], pe);
         wait_idle($sformatf("v%0d_idle_timeout", i), 50);
         check($sformatf("v%0d_issue_count", i), n_issue - n_iss0, vecs[i].exp_issue);
         check($sformatf("v%0d_valid_cycles", i), n_valid_neg - n_val0, vecs[i].exp_issue);
         check($sformatf("v%0d_rsp_count", i), n_rsp - n_rsp0, vecs[i].exp_rsp);
         if (vecs[i].exp_issue) check($sformatf("v%0d_issue_lat", i), last_issue_edge - pe, 1);
         if (vecs[i].exp_rsp)
            check($sformatf("v%0d_rsp_lat", i), last_rsp_edge - pe, vecs[i].exp_issue ? 3 : 2);
      end

      // INVAL_ALL with the handler busy for 64 cycles after accepting.
      hdl_lat = 64;
      rsp_vis_cyc = -1;
      r = mk(3'd3, 49'h0_0000_2000, 64'h0, 3'd6, 6'h0a, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b0);
      push_req(r, pe);
      wait_idle("ia_idle_timeout", 200);
      check("ia_issue_lat", last_issue_edge - pe, 1);
      check("ia_busy_window", ready_rise_cyc - last_issue_edge, 64);
      check("ia_rsp_after_ready", rsp_vis_cyc - ready_rise_cyc, 1);
      hdl_lat = 0;

      // Three INVAL_BY_SET pushes against a stalled handler.
      hdl_stall = 1'b1;
      @(posedge clk);
      #1;
      issue_hist.delete();
      push_req(mk(3'd2, 49'h0_0000_0200, 64'h0F, 3'd1, 6'h01, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0), ea);
      push_req(mk(3'd2, 49'h0_0000_0240, 64'h0F, 3'd1, 6'h02, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0), eb);
      check("set_b_back_to_back", eb - ea, 1);
      check("set_full_ready_low", core_req_ready_o, 0);
      fork
         push_req(mk(3'd2, 49'h0_0000_0280, 64'h0F, 3'd1, 6'h03, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0), ec);
         begin
            repeat (4) @(negedge clk);
            check("set_still_full", core_req_ready_o, 0);
            check("set_no_issue_while_stalled", cmo_req_valid_o & cmo_req_ready_i, 0);
            hdl_stall = 1'b0;
         end
      join
      wait_idle("set_idle_timeout", 50);
      check("set_issue_count", issue_hist.size(), 3);
      check("set_c_after_pop", ec - issue_hist[0], 1);
      check("set_issue_spacing", issue_hist[1] - issue_hist[0], 2);

      // Response held off for 10 cycles with a second request queued behind it.
      rsp_ready_i = 1'b0;
      issue_hist.delete();
      push_req(vecs[1], e1);
      push_req(mk(3'd0, 49'h0_0000_0300, 64'h0, 3'd2, 6'h04, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0), pe);
      n = 0;
      @(negedge clk);
      while (!rsp_valid_o && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!rsp_valid_o) fail_now("nl_rsp_timeout");
      for (int k = 0; k < 10; k++) begin
         check("nl_rsp_hold", {rsp_valid_o, rsp_error_o, rsp_sid_o, rsp_tid_o},
               {1'b1, 1'b0, 3'd1, 6'h03});
         check("nl_next_not_issued", cmo_req_valid_o, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      rsp_ready_i = 1'b1;
      wait_idle("nl_idle_timeout", 50);
      check("nl_issue_count", issue_hist.size(), 2);
      check("nl_next_after_rsp", issue_hist[1] - last_rsp_edge, 1);

      // Reset in WAIT_DONE with two requests still queued.
      hdl_lat = 1000;
      push_req(mk(3'd0, 49'h0_0000_0400, 64'h0, 3'd6, 6'h3c, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0), pe);
      push_req(vecs[1], pe);
      push_req(vecs[2], pe);
      check("rst_pre_busy", busy_o, 1);
      check("rst_pre_full", core_req_ready_o, 0);
      check("rst_pre_sid", rsp_sid_o, 6);
      check("rst_pre_tid", rsp_tid_o, 6'h3c);
      #2;
      rst_ni = 1'b0;
      #1;
      check("rst_async_cmo_valid", cmo_req_valid_o, 0);
      check("rst_async_rsp_valid", rsp_valid_o, 0);
      check("rst_async_sid_tid", {rsp_sid_o, rsp_tid_o, rsp_error_o}, 0);
      check("rst_async_busy", busy_o, 0);
      check("rst_async_core_ready", core_req_ready_o, 1);
      issue_q.delete();
      rsp_q.delete();
      hdl_lat = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      @(negedge clk);
      check("rst_after_busy", busy_o, 0);
      check("rst_after_core_ready", core_req_ready_o, 1);
      check("rst_after_cmo_valid", cmo_req_valid_o, 0);
      repeat (3) @(negedge clk);
      check("rst_after_stays_idle", {busy_o, cmo_req_valid_o, rsp_valid_o}, 0);

      check("scoreboard_drained", issue_q.size() + rsp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hpdcache_cmo_req_adapter.md
# hpdcache_cmo_req_adapter

Front-end stage feeding the HPDcache CMO handler. Accepts cache-management requests from the core request path (encoded opcode, address, write data, source/transaction IDs), buffers them in a small FIFO, and decodes each to the one-hot CMO operation vector. It issues requests to the handler strictly one at a time, detects handler completion, and returns an optional completion response to the requester, with an error flag for illegal opcodes.

## Interface
Parameters:
- FIFO_DEPTH, 2, request buffer entries (power of 2, ≥2)
- ADDR_WIDTH, 49, request address width
- WDATA_WIDTH, 64, write data width (only the least-significant word is meaningful)
- SID_WIDTH, 3, source ID width
- TID_WIDTH, 6, transaction ID width

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- core_req_valid_i  in  1  core CMO request valid
- core_req_ready_o  out  1  request accepted when valid & ready
- core_req_op_i  in  3  0=FENCE, 1=INVAL_BY_NLINE, 2=INVAL_BY_SET, 3=INVAL_ALL, 4..7 illegal
- core_req_addr_i  in  ADDR_WIDTH  target address (nline/set)
- core_req_wdata_i  in  WDATA_WIDTH  parameters (way vector in low bits for INVAL_BY_SET)
- core_req_sid_i / core_req_tid_i  in  SID_WIDTH / TID_WIDTH  requester IDs
- core_req_need_rsp_i  in  1  completion response requested
- cmo_req_valid_o  out  1  request to CMO handler
- cmo_req_ready_i  in  1  handler ready (high only when handler idle)
- cmo_req_op_o  out  4  one-hot {is_inval_all, is_inval_by_set, is_inval_by_nline, is_fence} (bit3..bit0)
- cmo_req_addr_o  out  ADDR_WIDTH  forwarded address
- cmo_req_wdata_o  out  WDATA_WIDTH  forwarded write data
- rsp_valid_o  out  1  completion response valid
- rsp_ready_i  in  1  response consumer ready
- rsp_sid_o / rsp_tid_o  out  SID_WIDTH / TID_WIDTH  IDs of completed request
- rsp_error_o  out  1  1 = illegal opcode, not executed
- busy_o  out  1  FIFO non-empty or FSM not IDLE

## Operation
- FIFO: pointer-based, stores raw opcode, addr, wdata, sid, tid, need_rsp. core_req_ready_o = !full. A pop in the same cycle does not free a slot for a push (no full-bypass). No empty-bypass.
- Decode is combinational from the FIFO head. Opcodes 0..3 map to one-hot bits 0..3. Illegal opcodes are never presented to the handler.
- FSM states IDLE, WAIT_DONE, RSP. On entering WAIT_DONE or RSP, sid, tid and need_rsp are latched from the head.
  - IDLE, head legal: cmo_req_valid_o=1. On cmo_req_ready_i, pop the head and go to WAIT_DONE.
  - IDLE, head illegal: pop the head. If need_rsp, go to RSP with error=1; otherwise stay in IDLE.
  - WAIT_DONE: cmo_req_valid_o=0. When cmo_req_ready_i=1 (handler back in idle), go to RSP (error=0) if need_rsp, otherwise go to IDLE.
  - RSP: rsp_valid_o=1 with latched IDs and error. On rsp_ready_i, go to IDLE.
- At most one request is outstanding at the handler. No new issue happens until the FSM returns to IDLE.
- cmo_req_addr_o, cmo_req_wdata_o and cmo_req_op_o are valid only while cmo_req_valid_o=1. They are driven from the FIFO head and held stable while valid and not ready.

## Timing
- Reset: FIFO empty, FSM IDLE. cmo_req_valid_o=0, rsp_valid_o=0, rsp_error_o=0, rsp_sid_o=0, rsp_tid_o=0, busy_o=0, core_req_ready_o=1.
- Push at edge N: cmo_req_valid_o at cycle N+1 (FSM IDLE, handler ready → issued at N+1).
- Completion: issue at edge M. The handler's ready is sampled from cycle M+1. A fence that finishes immediately gives ready=1 at M+1 → RSP at M+2.
- Minimum spacing between successive handler issues: 2 cycles without response, 3 with an immediately accepted response.
- Illegal opcode with need_rsp: rsp_valid_o asserted one cycle after it reaches the head.
- rsp_valid_o and its payload stay stable until rsp_ready_i. They never drop without a handshake.
- Reset asserted mid-operation (any state) aborts immediately. FIFO contents and the in-flight response are lost, and outputs take their reset values asynchronously.

## Test plan
- FENCE (op 0), sid=2, tid=0x15, need_rsp=1, handler ready constant 1 → cmo_req_op_o=4'b0001 at N+1; rsp_valid_o with sid=2, tid=0x15, error=0 at N+3.
- INVAL_ALL (op 3), need_rsp=1, handler ready low for 64 cycles after accept → no response before ready returns; rsp_valid_o exactly 1 cycle after ready rises; cmo_req_op_o=4'b1000.
- Three back-to-back INVAL_BY_SET pushes, handler stalled → core_req_ready_o=0 after 2 accepts; third accepted after the first pop frees a slot; wdata 0x0F forwarded intact; issues in order.
- Illegal op 5, need_rsp=1 → cmo_req_valid_o never asserted; rsp_error_o=1 with matching IDs. Same op with need_rsp=0 → silently dropped, busy_o returns to 0.
- INVAL_BY_NLINE, addr=0x1_2340, rsp_ready_i low for 10 cycles → response held stable for all 10 cycles; next queued request not issued until the response handshake completes.
- Assert rst_ni low while in WAIT_DONE with 2 FIFO entries → all outputs at reset values in the same cycle; after release, busy_o=0 and core_req_ready_o=1.
